ddp_arbiter: RTL and testbench

Shares one `compute_ddp`-style compute unit (start/done handshake, registered result) between `N_REQ` requesters. The block sits between the requesters and the compute unit. It picks one pending request by round-robin, latches its operands, pulses `cu_start`, waits for `cu_done`, then returns the result to the winner. A done-timeout guards against a hung unit.

---
 rtl/ddp_pkg.sv | 14 +
 rtl/ddp_arbiter_rr_pick.sv | 33 +++
 rtl/ddp_arbiter.sv | 137 +++++++++++++
 tb/tb_ddp_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddp_pkg.sv
// Shared types and default widths for the ddp compute-unit arbiter.
package ddp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ddp_state_e;

  localparam int DDP_OP_W  = 4;
  localparam int DDP_RES_W = 5;

endpackage

// File: rtl/ddp_arbiter_rr_pick.sv
// Combinational round-robin picker: searches upward from the requester after
// `last`, wrapping around, and returns the first pending request.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last,
  output logic [N_REQ-1:0]         win,
  output logic [$clog2(N_REQ)-1:0] win_idx,
  output logic                     any
);

  localparam int IDX_W = $clog2(N_REQ);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search loop so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last) + off) % N_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        win_idx    = IDX_W'(idx);
        win[idx]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddp_arbiter.sv
// Round-robin arbiter sharing one start/done compute unit between N_REQ
// requesters, with a done-timeout that aborts a hung transaction.
module ddp_arbiter
  import ddp_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int OP_W    = DDP_OP_W,
  parameter int RES_W   = DDP_RES_W,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*OP_W-1:0]   a_in,
  input  logic [N_REQ*OP_W-1:0]   b_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        res_valid,
  output logic [RES_W-1:0]        res,
  output logic                    err,
  output logic                    busy,
  output logic                    cu_start,
  output logic [OP_W-1:0]         cu_a,
  output logic [OP_W-1:0]         cu_b,
  input  logic [RES_W-1:0]        cu_c,
  input  logic                    cu_done
);

  localparam int               IDX_W    = $clog2(N_REQ);
  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  ddp_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic [OP_W-1:0]  cu_a_q, cu_a_d;
  logic [OP_W-1:0]  cu_b_q, cu_b_d;
  logic [RES_W-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0] pick_win;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req     (req),
    .last    (last_q),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    win_idx_d = win_idx_q;
    cu_a_d    = cu_a_q;
    cu_b_d    = cu_b_q;
    res_d     = res_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = ISSUE;
          gnt_d     = pick_win;
          win_idx_d = pick_idx;
          cu_a_d    = a_in[int'(pick_idx)*OP_W +: OP_W];
          cu_b_d    = b_in[int'(pick_idx)*OP_W +: OP_W];
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // A done on the final count still counts as a normal completion.
        if (cu_done) begin
          state_d = RESP;
          res_d   = cu_c;
          err_d   = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RESP;
          res_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = win_idx_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= LAST_RST;
      win_idx_q <= '0;
      cu_a_q    <= '0;
      cu_b_q    <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      win_idx_q <= win_idx_d;
      cu_a_q    <= cu_a_d;
      cu_b_q    <= cu_b_d;
      res_q     <= res_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign res       = res_q;
  assign cu_a      = cu_a_q;
  assign cu_b      = cu_b_q;
  assign cu_start  = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == RESP) ? gnt_q : '0;
  assign err       = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_ddp_arbiter.sv
// Directed bench for ddp_arbiter with an adder-style compute unit stub
// (2-cycle start-to-done latency, optional hang and spurious-done injection).
module tb_ddp_arbiter;

  localparam int N_REQ = 4;
  localparam int OP_W  = 4;
  localparam int RES_W = 5;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*OP_W-1:0] a_in;
  logic [N_REQ*OP_W-1:0] b_in;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   res_valid;
  logic [RES_W-1:0]   res;
  logic               err;
  logic               busy;
  logic               cu_start;
  logic [OP_W-1:0]    cu_a;
  logic [OP_W-1:0]    cu_b;
  logic [RES_W-1:0]   cu_c;
  logic               cu_done;

  logic               hang;
  logic               spur;
  logic [1:0]         pipe;
  logic [RES_W-1:0]   c_q;

  int n_tests = 0;
  int n_fail  = 0;

  ddp_arbiter #(.N_REQ(N_REQ), .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res       (res),
    .err       (err),
    .busy      (busy),
    .cu_start  (cu_start),
    .cu_a      (cu_a),
    .cu_b      (cu_b),
    .cu_c      (cu_c),
    .cu_done   (cu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compute unit stub: result a+b, done two cycles after the start pulse.
  always @(posedge clk) begin
    if (rst) begin
      pipe <= 2'b00;
      c_q  <= '0;
    end else begin
      pipe <= {pipe[0], cu_start};
      if (cu_start) c_q <= {1'b0, cu_a} + {1'b0, cu_b};
    end
  end
  assign cu_done = (pipe[1] & ~hang) | spur;
  assign cu_c    = spur ? 5'h1F : c_q;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; hang = 1'b0; spur = 1'b0;
    cyc(); cyc(); cyc();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_res", res, 0);
    check("rst_start", cu_start, 0);
    check("rst_cu_a", cu_a, 0);
    rst = 1'b0;
    cyc();
    check("idle_busy", busy, 0);

    // Single request: 0xF + 0x1 = 0x10.
    req = 4'b0001; a_in = 16'h000F; b_in = 16'h0001;
    cyc();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_start", cu_start, 1);
    check("t1_cu_a", cu_a, 4'hF);
    check("t1_cu_b", cu_b, 4'h1);
    cyc();
    check("t1_start_pulse", cu_start, 0);
    check("t1_wait_rv", res_valid, 0);
    cyc();
    check("t1_wait_gnt", gnt, 4'b0001);
    cyc();
    check("t1_rv", res_valid, 4'b0001);
    check("t1_res", res, 5'h10);
    check("t1_err", err, 0);
    req = 4'b0000;
    cyc();
    check("t1_idle_busy", busy, 0);
    check("t1_idle_rv", res_valid, 0);
    check("t1_res_hold", res, 5'h10);

    // All four requesting after reset: order 0,1,2,3,0, result 2*i.
    rst = 1'b1;
    cyc();
    rst = 1'b0; req = 4'b1111; a_in = 16'h3210; b_in = 16'h3210;
    for (int t = 0; t < 5; t++) begin
      int w;
      w = t % 4;
      cyc();
      check("t2_gnt", gnt, 32'(4'b0001 << w));
      check("t2_start", cu_start, 1);
      cyc(); cyc(); cyc();
      check("t2_rv", res_valid, 32'(4'b0001 << w));
      check("t2_res", res, 32'(2 * w));
      cyc();
      check("t2_idle", busy, 0);
    end

    // Requester 2 wins, then 1 and 3 arrive during WAIT: grant 3, then 1.
    req = 4'b0100; a_in = 16'h0500; b_in = 16'h0300;
    cyc();
    check("t3_gnt2", gnt, 4'b0100);
    cyc();
    req = 4'b1010; a_in = 16'h7540; b_in = 16'h9320;
    cyc(); cyc();
    check("t3_rv2", res_valid, 4'b0100);
    check("t3_res2", res, 5'h08);
    check("t3_cu_a_stable", cu_a, 4'h5);
    cyc();
    check("t3_idle_a", busy, 0);
    cyc();
    check("t3_gnt3", gnt, 4'b1000);
    check("t3_cu_a3", cu_a, 4'h7);
    cyc(); cyc(); cyc();
    check("t3_rv3", res_valid, 4'b1000);
    check("t3_res3", res, 5'h10);
    req = 4'b0010;
    cyc();
    cyc();
    check("t3_gnt1", gnt, 4'b0010);
    cyc(); cyc(); cyc();
    check("t3_rv1", res_valid, 4'b0010);
    check("t3_res1", res, 5'h06);
    req = 4'b0000;
    cyc();

    // Hung unit: abort at k+18 with res=0, err=1, then a normal transaction.
    hang = 1'b1; req = 4'b0001; a_in = 16'h0001; b_in = 16'h0001;
    cyc();
    check("t4_gnt", gnt, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      cyc();
      check("t4_wait_rv", res_valid, 0);
    end
    cyc();
    check("t4_rv", res_valid, 4'b0001);
    check("t4_res", res, 0);
    check("t4_err", err, 1);
    hang = 1'b0;
    cyc();
    check("t4_idle_err", err, 0);
    check("t4_idle_busy", busy, 0);
    cyc();
    check("t4_gnt2", gnt, 4'b0001);
    cyc(); cyc(); cyc();
    check("t4_rv2", res_valid, 4'b0001);
    check("t4_res2", res, 5'h02);
    check("t4_err2", err, 0);
    req = 4'b0000;
    cyc();

    // Reset in WAIT: everything clears and requester 0 has priority again.
    req = 4'b0010; a_in = 16'h0030; b_in = 16'h0040;
    cyc();
    check("t5_gnt1", gnt, 4'b0010);
    check("t5_cu_a", cu_a, 4'h3);
    cyc();
    rst = 1'b1;
    cyc();
    check("t5_gnt", gnt, 0);
    check("t5_rv", res_valid, 0);
    check("t5_err", err, 0);
    check("t5_start", cu_start, 0);
    check("t5_busy", busy, 0);
    check("t5_res", res, 0);
    check("t5_cu_a0", cu_a, 0);
    check("t5_cu_b0", cu_b, 0);
    rst = 1'b0; req = 4'b0101; a_in = 16'h0602; b_in = 16'h0805;
    cyc();
    check("t5_gnt0", gnt, 4'b0001);
    check("t5_cu_b", cu_b, 4'h5);
    cyc(); cyc(); cyc();
    check("t5_rv0", res_valid, 4'b0001);
    check("t5_res0", res, 5'h07);
    req = 4'b0100;
    cyc();
    cyc();
    check("t5_gnt2", gnt, 4'b0100);
    cyc(); cyc(); cyc();
    check("t5_rv2", res_valid, 4'b0100);
    check("t5_res2", res, 5'h0E);
    req = 4'b0000;
    cyc();

    // Winner drops req in WAIT; spurious done in IDLE has no effect.
    req = 4'b1000; a_in = 16'hA000; b_in = 16'h3000;
    cyc();
    check("t6_gnt", gnt, 4'b1000);
    cyc();
    req = 4'b0000;
    cyc(); cyc();
    check("t6_rv", res_valid, 4'b1000);
    check("t6_res", res, 5'h0D);
    cyc();
    spur = 1'b1;
    cyc();
    check("t6_spur_busy", busy, 0);
    check("t6_spur_rv", res_valid, 0);
    check("t6_spur_res", res, 5'h0D);
    spur = 1'b0;
    cyc();
    check("t6_after_busy", busy, 0);
    check("t6_after_start", cu_start, 0);

    // Done on the final timeout count wins over the abort.
    hang = 1'b1; req = 4'b0001; a_in = 16'h0002; b_in = 16'h0003;
    cyc();
    check("t7_gnt", gnt, 4'b0001);
    for (int i = 0; i < 15; i++) cyc();
    check("t7_wait_busy", busy, 1);
    cyc();
    spur = 1'b1;
    cyc();
    spur = 1'b0; hang = 1'b0; req = 4'b0000;
    check("t7_rv", res_valid, 4'b0001);
    check("t7_res", res, 5'h1F);
    check("t7_err", err, 0);
    cyc();
    check("t7_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
